// File: rtl/wired_ibus_refill.sv
// wired_ibus_refill
//   Bus-side responder for the icache miss / uncached fetch path. It accepts
//   one read request at a time and issues a single AXI4 INCR read burst. The
//   returned words go back to the icache one per handshake, through a
//   one-entry output register, each tagged with its word index in the line.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_*                 icache request (valid/ready, address, uncached flag)
//   resp_*                returned word (valid/ready, data, idx, last, err)
//   flush_i               abandon the current transaction
//   ar*                   AXI read address channel (fixed size, INCR, id)
//   r*                    AXI read data channel (rlast is not used)
module wired_ibus_refill #(
   parameter int         LINE_WORDS = 4,
   parameter logic [3:0] AXI_ID     = 4'd0,
   localparam int        IDXW       = $clog2(LINE_WORDS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [31:0]     req_addr,
   input  logic            req_uncached,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [31:0]     resp_data,
   output logic [IDXW-1:0] resp_idx,
   output logic            resp_last,
   output logic            resp_err,
   input  logic            flush_i,
   output logic            arvalid,
   input  logic            arready,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic [3:0]      arid,
   input  logic            rvalid,
   output logic            rready,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast
);

   typedef enum logic [1:0] {IDLE, AR, R, DRAIN} state_t;

   state_t          state, state_d;
   logic [7:0]      beats;     // beats accepted so far in this burst
   logic [IDXW-1:0] cnt;       // word index of the next beat
   logic            discard;   // flush seen while the address was pending
   logic            done;      // final beat accepted, waiting for drain
   logic            beat;
   logic            last_beat;
   logic            unused_sig;

   // End of burst comes from our own beat count; rlast is informational.
   assign unused_sig = ^{rlast, req_addr[1:0]};

   assign arsize    = 3'b010;
   assign arburst   = 2'b01;
   assign arid      = AXI_ID;
   assign beat      = rvalid && rready;
   assign last_beat = (beats == arlen);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d   = state;
      req_ready = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !flush_i;
            if (req_valid && !flush_i) state_d = AR;
         end
         AR: begin
            // arvalid is never withdrawn; a flush only diverts us to DRAIN.
            arvalid = 1'b1;
            if (arready) state_d = (discard || flush_i) ? DRAIN : R;
         end
         R: begin
            rready = !done && (!resp_valid || resp_ready);
            if (flush_i)
               state_d = (done || (rvalid && rready && last_beat)) ? IDLE : DRAIN;
            else if (done && resp_valid && resp_ready)
               state_d = IDLE;
         end
         DRAIN: begin
            rready = 1'b1;
            if (rvalid && last_beat) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         araddr     <= '0;
         arlen      <= '0;
         beats      <= '0;
         cnt        <= '0;
         discard    <= 1'b0;
         done       <= 1'b0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_idx   <= '0;
         resp_last  <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         if (state == IDLE && req_valid && req_ready) begin
            beats   <= '0;
            discard <= 1'b0;
            done    <= 1'b0;
            if (req_uncached) begin
               araddr <= {req_addr[31:2], 2'b00};
               arlen  <= 8'd0;
               cnt    <= req_addr[IDXW+1:2];
            end else begin
               araddr <= {req_addr[31:IDXW+2], {(IDXW+2){1'b0}}};
               arlen  <= 8'(LINE_WORDS - 1);
               cnt    <= '0;
            end
         end
         if (state == AR && flush_i) discard <= 1'b1;

         // Beats are counted in R and DRAIN alike so DRAIN knows the end.
         if (beat) begin
            beats <= beats + 8'd1;
            cnt   <= cnt + 1'b1;
         end

         if (state == R) begin
            if (resp_valid && resp_ready) resp_valid <= 1'b0;
            if (beat && !flush_i) begin
               resp_valid <= 1'b1;
               resp_data  <= rdata;
               resp_idx   <= cnt;
               resp_err   <= (rresp != 2'b00);
               resp_last  <= last_beat;
               if (last_beat) done <= 1'b1;
            end
            // A flush drops any word still sitting in the output register.
            if (flush_i) resp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wired_ibus_refill.sv
module tb_wired_ibus_refill;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_uncached;
   logic [31:0] req_addr;
   logic        resp_valid, resp_ready, resp_last, resp_err;
   logic [31:0] resp_data;
   logic [1:0]  resp_idx;
   logic        flush_i;
   logic        arvalid, arready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [3:0]  arid;
   logic        rvalid, rready, rlast;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wired_ibus_refill #(.LINE_WORDS(4), .AXI_ID(4'd0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_uncached(req_uncached),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_idx(resp_idx), .resp_last(resp_last), .resp_err(resp_err),
      .flush_i(flush_i),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst), .arid(arid),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rlast(rlast)
   );

   typedef struct {
      logic [31:0] addr;
      logic        unc;
      logic [31:0] exp_araddr;
      logic [7:0]  exp_arlen;
      logic [1:0]  idx0;
      int          err_beat;
      logic        stall;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Accept a request and let the address go out immediately.
   task automatic start_req(input logic [31:0] a, input logic u);
      req_valid = 1'b1; req_addr = a; req_uncached = u;
      step();
      req_valid = 1'b0;
      arready = 1'b1;
      step();
      arready = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int nb, sent, got, first_cyc, stall_cnt;
      logic hs, rv_s;
      nb = int'(v.exp_arlen) + 1;
      sent = 0; got = 0; first_cyc = -1; stall_cnt = 0;
      req_valid = 1'b1; req_addr = v.addr; req_uncached = v.unc;
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0; req_addr = '0;
      arready = 1'b1;
      @(negedge clk);
      chk("arvalid", 32'(arvalid), 32'd1);
      chk("araddr", araddr, v.exp_araddr);
      chk("arlen", 32'(arlen), 32'(v.exp_arlen));
      chk("arsize", 32'(arsize), 32'd2);
      chk("arburst", 32'(arburst), 32'd1);
      chk("arid", 32'(arid), 32'd0);
      step();
      arready = 1'b0;
      for (int cyc = 0; cyc < 60 && got < nb; cyc++) begin
         rvalid = (sent < nb);
         rdata  = 32'hC0DE_0000 + 32'(sent);
         rresp  = (sent == v.err_beat) ? 2'b10 : 2'b00;
         resp_ready = !(v.stall && got == 1 && stall_cnt < 3);
         if (v.stall && got == 1) stall_cnt++;
         @(negedge clk);
         hs = rvalid && rready;
         rv_s = resp_valid;
         if (resp_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            chk("resp_data", resp_data, 32'hC0DE_0000 + 32'(got));
            chk("resp_idx", 32'(resp_idx), 32'((int'(v.idx0) + got) % 4));
            chk("resp_last", 32'(resp_last), 32'(got == nb - 1));
            chk("resp_err", 32'(resp_err), 32'(got == v.err_beat));
            if (!resp_ready) chk("rready_full", 32'(rready), 32'd0);
         end
         step();
         if (hs) sent++;
         if (rv_s && resp_ready) got++;
      end
      rvalid = 1'b0; resp_ready = 1'b1;
      chk("words_got", 32'(got), 32'(nb));
      chk("beats_sent", 32'(sent), 32'(nb));
      chk("first_latency", 32'(first_cyc), 32'd1);
      @(negedge clk);
      chk("req_ready_after", 32'(req_ready), 32'd1);
      chk("resp_valid_after", 32'(resp_valid), 32'd0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      vecs[0] = '{32'h1C00_0124, 1'b0, 32'h1C00_0120, 8'd3, 2'd0, -1, 1'b0};
      vecs[1] = '{32'h1FE0_01E6, 1'b1, 32'h1FE0_01E4, 8'd0, 2'd1, -1, 1'b0};
      vecs[2] = '{32'h0000_1008, 1'b0, 32'h0000_1000, 8'd3, 2'd0, -1, 1'b1};
      vecs[3] = '{32'h2000_003C, 1'b0, 32'h2000_0030, 8'd3, 2'd0,  2, 1'b0};
      vecs[4] = '{32'h8000_000C, 1'b1, 32'h8000_000C, 8'd0, 2'd3,  0, 1'b0};

      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_uncached = 1'b0;
      resp_ready = 1'b1; flush_i = 1'b0; arready = 1'b0;
      rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
      step(); step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      step();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Flush in IDLE blocks acceptance.
      req_valid = 1'b1; req_addr = 32'h1C00_0124; flush_i = 1'b1;
      @(negedge clk);
      chk("idle_flush_req_ready", 32'(req_ready), 32'd0);
      step();
      req_valid = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      chk("idle_flush_arvalid", 32'(arvalid), 32'd0);
      step();

      // Flush after the second word is consumed, with the third pending.
      start_req(32'h4000_0000, 1'b0);
      rvalid = 1'b1; rdata = 32'h11; step();            // beat0
      rdata = 32'h22; step();                           // beat1, word0 taken
      rdata = 32'h33; step();                           // beat2, word1 taken
      rvalid = 1'b0; resp_ready = 1'b0; flush_i = 1'b1;
      @(negedge clk);
      chk("fl_pending_word", 32'(resp_valid), 32'd1);
      step();
      flush_i = 1'b0; resp_ready = 1'b1;
      @(negedge clk);
      chk("fl_resp_dropped", 32'(resp_valid), 32'd0);
      chk("fl_rready", 32'(rready), 32'd1);
      chk("fl_req_ready_0", 32'(req_ready), 32'd0);
      step();
      rvalid = 1'b1; rdata = 32'h44;                    // beat3, discarded
      @(negedge clk);
      chk("fl_rready_last", 32'(rready), 32'd1);
      chk("fl_req_ready_1", 32'(req_ready), 32'd0);
      step();
      rvalid = 1'b0;
      @(negedge clk);
      chk("fl_resp_valid_end", 32'(resp_valid), 32'd0);
      chk("fl_req_ready_back", 32'(req_ready), 32'd1);
      chk("fl_rready_idle", 32'(rready), 32'd0);
      step();

      // Flush while the address is stalled two cycles.
      req_valid = 1'b1; req_addr = 32'h5000_0040; req_uncached = 1'b0;
      step();
      req_valid = 1'b0; flush_i = 1'b1; arready = 1'b0;
      @(negedge clk);
      chk("ar_fl_arvalid0", 32'(arvalid), 32'd1);
      step();
      flush_i = 1'b0;
      @(negedge clk);
      chk("ar_fl_arvalid1", 32'(arvalid), 32'd1);
      chk("ar_fl_araddr", araddr, 32'h5000_0040);
      step();
      arready = 1'b1;
      @(negedge clk);
      chk("ar_fl_arvalid2", 32'(arvalid), 32'd1);
      step();
      arready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         rvalid = 1'b1; rdata = 32'hBAD0_0000 + 32'(b);
         @(negedge clk);
         chk("ar_fl_no_resp", 32'(resp_valid), 32'd0);
         chk("ar_fl_rready", 32'(rready), 32'd1);
         step();
      end
      rvalid = 1'b0;
      @(negedge clk);
      chk("ar_fl_req_ready", 32'(req_ready), 32'd1);
      chk("ar_fl_arvalid_end", 32'(arvalid), 32'd0);
      step();

      // Reset in R after one beat.
      start_req(32'h1C00_0124, 1'b0);
      rvalid = 1'b1; rdata = 32'h77; step();
      rvalid = 1'b0; resp_ready = 1'b0;
      @(negedge clk);
      chk("rs_resp_valid_pre", 32'(resp_valid), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; resp_ready = 1'b1;
      @(negedge clk);
      chk("rs_resp_valid", 32'(resp_valid), 32'd0);
      chk("rs_arvalid", 32'(arvalid), 32'd0);
      chk("rs_req_ready", 32'(req_ready), 32'd1);
      step();
      run_vec(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/wired_ibus_refill.md
Name: wired_ibus_refill

Overview:
- Bus-side responder for the instruction cache's miss/uncached fetch path: accepts one read request at a time and issues a single AXI4 read burst to memory.
- Streams returned words back to the icache one word per handshake, tagged with their word index within the line.
- Sits between the icache bus request/response port and the shared AXI read channel; one outstanding transaction, fixed ARID 0.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; power of 2, range 2..16. IDXW = log2(LINE_WORDS).
- AXI_ID, 0, constant driven on arid.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  icache read request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  32  fetch physical address
- req_uncached  in  1  1 = single-word read, 0 = full-line refill
- resp_valid  out  1  returned word valid
- resp_ready  in  1  icache accepts word
- resp_data  out  32  returned word
- resp_idx  out  IDXW  word index within line
- resp_last  out  1  final word of the transaction
- resp_err  out  1  rresp != OKAY for this beat
- flush_i  in  1  abandon current transaction
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- araddr  out  32  AXI read address
- arlen  out  8  AXI burst length minus one
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- arid  out  4  constant AXI_ID
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready
- rdata  in  32  AXI read data
- rresp  in  2  AXI read response
- rlast  in  1  AXI last beat (informational only)

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; arvalid, resp_valid, resp_last, resp_err = 0; rready = 0; beat counter = 0; discard flag = 0. req_ready is 1 the first cycle after reset.
- Clock/reset: clock clk; reset rst_n, synchronous, active-low.
- FSM states: IDLE, AR, R, DRAIN.
- IDLE:
  - req_ready = !flush_i.
  - On accept, latch the request and move to AR with arvalid=1 the next cycle.
  - Cached request: araddr = req_addr with the low log2(LINE_WORDS*4) bits cleared; arlen = LINE_WORDS-1; beat counter starts at 0.
  - Uncached request: araddr = req_addr & ~3; arlen = 0; beat counter starts at req_addr[IDXW+1:2].
- AR:
  - arvalid held 1 and araddr/arlen held stable until arready (AXI rule; flush never withdraws arvalid).
  - On arready, go to R, or to DRAIN if flush_i was seen during AR (sticky discard flag).
- R:
  - rready = !resp_valid || resp_ready (one-entry output register).
  - On an rvalid && rready beat, the next cycle registers: resp_valid=1, resp_data=rdata, resp_idx=counter, resp_err=(rresp!=0), resp_last=(beats_seen==arlen). The counter then increments modulo LINE_WORDS.
  - Latency: beat accepted at cycle N gives resp_valid at N+1.
  - End of burst is decided by the internal beat count, not rlast. After the final beat is accepted, go to IDLE once the output register drains.
  - req_ready = 0 in every state except IDLE.
- DRAIN: rready = 1, resp_valid forced 0, beats counted and discarded. After the final beat, return to IDLE.
- flush_i:
  - In R: resp_valid clears the next cycle (an unconsumed word is dropped); go to DRAIN; remaining beats are discarded.
  - In IDLE: blocks acceptance that cycle.
  - In DRAIN: no effect.
  - Flush in the same cycle as the final beat: that beat is discarded and the FSM goes to IDLE.
- Error beats do not terminate the burst; all beats still flow.
- resp_* outputs hold stable while resp_valid && !resp_ready.
- Reset mid-burst returns to IDLE immediately. The external AXI fabric is reset together with this block.

Test Plan:
- Cached refill, req_addr=0x1C000124, LINE_WORDS=4, arready=1, rvalid every cycle. Required: araddr=0x1C000120, arlen=3, arsize=2, arburst=1; four resp beats with idx 0,1,2,3; resp_last only on idx 3; first resp_valid one cycle after the first r beat; req_ready=1 again after the last word is taken.
- Uncached, req_addr=0x1FE001E6. Required: araddr=0x1FE001E4, arlen=0; one resp with idx=1, resp_last=1.
- Backpressure: hold resp_ready=0 for 3 cycles after the first word during a refill. Required: rready=0 while the buffer is full; data/idx stable; no beat lost or duplicated; final order 0..3.
- Flush after the second beat is consumed. Required: resp_valid=0 from the next cycle; rready=1 until the 4th beat; req_ready stays 0 until then, then returns to 1. Also: flush while arvalid=1 and arready=0 for 2 cycles. Required: arvalid stays 1 until arready; no resp beats for that burst.
- rresp=2'b10 on beat 2 of a refill. Required: resp_err=1 only on idx 2; all four beats delivered; resp_last on idx 3.
- rst_n=0 during R after 1 beat. Required: next cycle resp_valid=0, arvalid=0, req_ready=1; a new request then behaves as in the first scenario.
